// File: rtl/systolic_feeder_pkg.sv
// Purpose: shared types and constants for the systolic operand feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_feeder_pkg;

  // Default operand width, matches the systolic_array a_in/b_in lanes.
  localparam int FEED_DATA_W = 16;

  // Feeder sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feed_state_t;

  // Constant helper for sizing localparams.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_feeder_matrix_buf.sv
// Purpose: NxN operand register file, one write port, N skewed read lanes.
// Latency: write commits at the clock edge; reads are combinational on (lane, step).
// Backpressure: none; the caller gates wr_en, out-of-range addresses are dropped.
module systolic_feeder_matrix_buf
  import systolic_feeder_pkg::*;
#(
  parameter int N         = 2,
  parameter int DATA_W    = FEED_DATA_W,
  parameter int IDX_W     = 1,
  parameter int STEP_W    = 2,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_row,
  input  logic [IDX_W-1:0]    wr_col,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [STEP_W-1:0]   step,
  output logic [N*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [N][N];

  // Storage: cleared by reset, otherwise last in-range write wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Skewed read: lane l shows element k where step == l + k. A (TRANSPOSE=0)
  // walks along row l, B (TRANSPOSE=1) walks down column l. Outside the
  // diagonal window the lane reads zero.
  always_comb begin
    rd_data = '0;
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(step) == l + k) begin
          rd_data[l*DATA_W +: DATA_W] = TRANSPOSE ? mem[k][l] : mem[l][k];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Purpose: buffers A/B and drives clear, skewed operand streams and drain to systolic_array.
// Latency: start to done = 2N + DRAIN_CYC + 1 cycles; all outputs registered.
// Backpressure: wr_ready = ~busy drops writes mid-sequence; start is ignored unless IDLE.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter  int N         = 2,
  parameter  int DATA_W    = FEED_DATA_W,
  parameter  int DRAIN_CYC = N + 1,
  localparam int IDX_W     = max_int(1, $clog2(N))
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [IDX_W-1:0]    wr_row,
  input  logic [IDX_W-1:0]    wr_col,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ready,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                array_clr,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N*DATA_W-1:0] b_out
);

  // One counter serves both the stream steps and the drain cycles.
  localparam int MAX_CNT = max_int(2*N - 2, DRAIN_CYC - 1);
  localparam int STEP_W  = max_int(1, $clog2(MAX_CNT + 1));
  localparam logic [STEP_W-1:0] STREAM_LAST = STEP_W'(2*N - 2);
  localparam logic [STEP_W-1:0] DRAIN_LAST  = STEP_W'(DRAIN_CYC - 1);

  feed_state_t        state, state_nxt;
  logic [STEP_W-1:0]  step, step_nxt, step_inc;
  logic               wr_acc;
  logic [N*DATA_W-1:0] a_rd, b_rd;

  // Busy is low during the done cycle too, so the buffers may be written then.
  assign wr_ready = ~busy;
  assign wr_acc   = wr_en & wr_ready;

  // The buffers are addressed with the next step so the operand lands in
  // the output register on the same edge the step advances.
  systolic_feeder_matrix_buf #(
    .N(N), .DATA_W(DATA_W), .IDX_W(IDX_W), .STEP_W(STEP_W), .TRANSPOSE(1'b0)
  ) u_buf_a (
    .clk(clk), .reset(reset), .wr_en(wr_acc & ~wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .step(step_nxt), .rd_data(a_rd)
  );

  systolic_feeder_matrix_buf #(
    .N(N), .DATA_W(DATA_W), .IDX_W(IDX_W), .STEP_W(STEP_W), .TRANSPOSE(1'b1)
  ) u_buf_b (
    .clk(clk), .reset(reset), .wr_en(wr_acc & wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .step(step_nxt), .rd_data(b_rd)
  );

  // State and step counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // Sequencing: the counter saturates rather than wrapping and restarts at
  // zero on entry to CLEAR and again on entry to DRAIN.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    step_inc  = (step == '1) ? step : step + STEP_W'(1);
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CLEAR;
          step_nxt  = '0;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_STREAM;
        step_nxt  = '0;
      end
      ST_STREAM: begin
        if (step == STREAM_LAST) begin
          state_nxt = ST_DRAIN;
          step_nxt  = '0;
        end else begin
          step_nxt  = step_inc;
        end
      end
      ST_DRAIN: begin
        if (step == DRAIN_LAST) begin
          state_nxt = ST_DONE;
          step_nxt  = '0;
        end else begin
          step_nxt  = step_inc;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  // Output registers decoded from the next state; operands only in STREAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      array_clr <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else begin
      busy      <= (state_nxt == ST_CLEAR) || (state_nxt == ST_STREAM) ||
                   (state_nxt == ST_DRAIN);
      done      <= (state_nxt == ST_DONE);
      array_clr <= (state_nxt == ST_CLEAR);
      a_out     <= (state_nxt == ST_STREAM) ? a_rd : '0;
      b_out     <= (state_nxt == ST_STREAM) ? b_rd : '0;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Purpose: directed self-checking bench for systolic_feeder at N=2 and N=3.
// Latency: checks cycle-exact timing of clear, skewed stream, drain and done.
// Backpressure: exercises dropped writes while busy and ignored starts.
module tb_systolic_feeder;

  localparam int MAXC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_en3, wr_sel;
  logic [1:0]  wr_row, wr_col;
  logic [15:0] wr_data;
  logic        start, start3;

  logic        wr_ready, busy, done, array_clr;
  logic [31:0] a_out, b_out;
  logic        wr_ready3, busy3, done3, array_clr3;
  logic [47:0] a_out3, b_out3;

  always #5 clk = ~clk;

  systolic_feeder #(.N(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row[0:0]), .wr_col(wr_col[0:0]), .wr_data(wr_data),
    .wr_ready(wr_ready), .start(start), .busy(busy), .done(done),
    .array_clr(array_clr), .a_out(a_out), .b_out(b_out)
  );

  systolic_feeder #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en3), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_ready(wr_ready3), .start(start3), .busy(busy3), .done(done3),
    .array_clr(array_clr3), .a_out(a_out3), .b_out(b_out3)
  );

  int total = 0;
  int bad   = 0;

  logic [47:0] cap_a [0:MAXC];
  logic [47:0] cap_b [0:MAXC];
  logic        cap_busy [0:MAXC];
  logic        cap_clr  [0:MAXC];
  logic        cap_rdy  [0:MAXC];
  int          done_cyc, done_cnt, clr_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input bit n3, input bit sel, input int row, input int col,
                    input logic [15:0] d);
    wr_sel  = sel;
    wr_row  = row[1:0];
    wr_col  = col[1:0];
    wr_data = d;
    if (n3) wr_en3 = 1'b1; else wr_en = 1'b1;
    tick();
    wr_en  = 1'b0;
    wr_en3 = 1'b0;
  endtask

  // Pulses start, then records MAXC cycles. Optional extra starts at cycles
  // s1/s2, a write of 99 to A[0][0] at w_cyc, or A[1][1]=9 alongside start.
  task automatic run_seq(input bit n3, input int s1, input int s2, input int w_cyc,
                         input bit w_at_start);
    done_cyc = 0;
    done_cnt = 0;
    clr_cnt  = 0;
    if (w_at_start) begin
      wr_sel = 1'b0; wr_row = 2'd1; wr_col = 2'd1; wr_data = 16'd9; wr_en = 1'b1;
    end
    if (n3) start3 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start3 = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      cap_a[c]    = n3 ? a_out3 : {16'h0, a_out};
      cap_b[c]    = n3 ? b_out3 : {16'h0, b_out};
      cap_busy[c] = n3 ? busy3 : busy;
      cap_clr[c]  = n3 ? array_clr3 : array_clr;
      cap_rdy[c]  = n3 ? wr_ready3 : wr_ready;
      if (n3 ? done3 : done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (n3 ? array_clr3 : array_clr) clr_cnt++;
      if (!n3) start = (c == s1) || (c == s2);
      if (c == w_cyc) begin
        wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 16'd99; wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  function automatic logic [15:0] lane(input logic [47:0] v, input int i);
    return v[i*16 +: 16];
  endfunction

  // Output-stationary array model fed from the captured streams: PE(i,j)
  // sees row lane i delayed by j and column lane j delayed by i.
  function automatic int array_result(input int i, input int j);
    int acc;
    acc = 0;
    for (int c = 1; c <= MAXC; c++) begin
      if (c - j >= 1 && c - i >= 1)
        acc += int'(lane(cap_a[c-j], i)) * int'(lane(cap_b[c-i], j));
    end
    return acc;
  endfunction

  logic [47:0] or_a, or_b;
  int          exp_res [0:1][0:1];

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_en3 = 1'b0; wr_sel = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0; start3 = 1'b0;
    exp_res[0][0] = 7;  exp_res[0][1] = 10;
    exp_res[1][0] = 15; exp_res[1][1] = 22;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_clr",   64'(array_clr), 64'd0);
    chk("rst_a",     64'(a_out), 64'd0);
    chk("rst_b",     64'(b_out), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd1);

    // Test 1: A = B = [1 2; 3 4]
    wr(0, 0, 0, 0, 16'd1); wr(0, 0, 0, 1, 16'd2); wr(0, 0, 1, 0, 16'd3); wr(0, 0, 1, 1, 16'd4);
    wr(0, 1, 0, 0, 16'd1); wr(0, 1, 0, 1, 16'd2); wr(0, 1, 1, 0, 16'd3); wr(0, 1, 1, 1, 16'd4);
    run_seq(0, 0, 0, 0, 0);
    chk("t1_clr_c1",  64'(cap_clr[1]), 64'd1);
    chk("t1_busy_c1", 64'(cap_busy[1]), 64'd1);
    chk("t1_a_c1",    64'(cap_a[1]), 64'd0);
    chk("t1_a_t0",    64'(cap_a[2]), 64'h0000_0001);
    chk("t1_a_t1",    64'(cap_a[3]), 64'h0003_0002);
    chk("t1_a_t2",    64'(cap_a[4]), 64'h0004_0000);
    chk("t1_b_t0",    64'(cap_b[2]), 64'h0000_0001);
    chk("t1_b_t1",    64'(cap_b[3]), 64'h0002_0003);
    chk("t1_b_t2",    64'(cap_b[4]), 64'h0004_0000);
    chk("t1_drain_a", 64'(cap_a[5] | cap_a[6] | cap_a[7]), 64'd0);
    chk("t1_busy_c7", 64'(cap_busy[7]), 64'd1);
    chk("t1_done_cyc", 64'(done_cyc), 64'd8);
    chk("t1_busy_c8", 64'(cap_busy[8]), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_clr_cnt",  64'(clr_cnt), 64'd1);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("t1_res_%0d%0d", i, j), 64'(array_result(i, j)), 64'(exp_res[i][j]));

    // Test 2: write of 99 to A[0][0] while busy is dropped
    run_seq(0, 0, 0, 3, 0);
    chk("t2_ready_busy", 64'(cap_rdy[3]), 64'd0);
    run_seq(0, 0, 0, 0, 0);
    chk("t2_replay_a00", 64'(lane(cap_a[2], 0)), 64'd1);

    // Test 3: start in STREAM and in the done cycle is ignored
    run_seq(0, 3, 8, 0, 0);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    chk("t3_done_cyc", 64'(done_cyc), 64'd8);
    chk("t3_clr_cnt",  64'(clr_cnt), 64'd1);
    chk("t3_busy_c9",  64'(cap_busy[9]), 64'd0);
    chk("t3_busy_end", 64'(cap_busy[MAXC]), 64'd0);

    // Test 4: write A[1][1]=9 together with start; later start runs fully
    run_seq(0, 0, 0, 0, 1);
    chk("t4_a_t2_lane1", 64'(lane(cap_a[4], 1)), 64'd9);
    chk("t4_done_cyc",   64'(done_cyc), 64'd8);

    // Test 5: reset during STREAM step 1
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("t5_a_step1", 64'(a_out), 64'h0003_0002);
    chk("t5_b_step1", 64'(b_out), 64'h0002_0003);
    reset = 1'b1; tick();
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_clr",  64'(array_clr), 64'd0);
    chk("t5_rst_a",    64'(a_out), 64'd0);
    chk("t5_rst_b",    64'(b_out), 64'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    chk("t5_idle",    64'(busy), 64'd0);
    run_seq(0, 0, 0, 0, 0);
    or_a = '0; or_b = '0;
    for (int c = 1; c <= MAXC; c++) begin
      or_a |= cap_a[c];
      or_b |= cap_b[c];
    end
    chk("t5_buf_a_zero", 64'(or_a), 64'd0);
    chk("t5_buf_b_zero", 64'(or_b), 64'd0);
    chk("t5_done_cyc",   64'(done_cyc), 64'd8);

    // Test 6: N=3, A = identity, B = 1..9
    for (int i = 0; i < 3; i++) wr(1, 0, i, i, 16'd1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        wr(1, 1, r, c, 16'(3*r + c + 1));
    run_seq(1, 0, 0, 0, 0);
    chk("t6_clr_c1", 64'(cap_clr[1]), 64'd1);
    chk("t6_a_t0", 64'(cap_a[2]), 64'h0000_0000_0001);
    chk("t6_a_t1", 64'(cap_a[3]), 64'h0000_0000_0000);
    chk("t6_a_t2", 64'(cap_a[4]), 64'h0000_0001_0000);
    chk("t6_a_t3", 64'(cap_a[5]), 64'h0000_0000_0000);
    chk("t6_a_t4", 64'(cap_a[6]), 64'h0001_0000_0000);
    chk("t6_b_t0", 64'(cap_b[2]), 64'h0000_0000_0001);
    chk("t6_b_t1", 64'(cap_b[3]), 64'h0000_0002_0004);
    chk("t6_b_t2", 64'(cap_b[4]), 64'h0003_0005_0007);
    chk("t6_b_t3", 64'(cap_b[5]), 64'h0006_0008_0000);
    chk("t6_b_t4", 64'(cap_b[6]), 64'h0009_0000_0000);
    chk("t6_drain", 64'(cap_a[7] | cap_b[7] | cap_a[10] | cap_b[10]), 64'd0);
    chk("t6_done_cyc", 64'(done_cyc), 64'd11);
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("t6_res_%0d%0d", i, j), 64'(array_result(i, j)), 64'(3*i + j + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
